// File: rtl/riscv_params_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_params_pkg
// Description : Core-wide parameters and the shared types used by the
//               data-memory arbiter: sequencer state encoding, the
//               registered memory command, and the default memory latency.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_params_pkg;

    localparam int INSTR_WIDTH    = 32;
    localparam int DATA_MEM_DEPTH = 65536;
    // Word-address width of the data memory. The command struct is sized
    // from this, so an arbiter built with a different DEPTH truncates or
    // zero-extends through explicit casts.
    localparam int DMEM_WORD_AW   = $clog2(DATA_MEM_DEPTH);
    localparam int DMEM_LATENCY   = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } dmem_arb_state_e;

    typedef struct packed {
        logic                    we;
        logic [DMEM_WORD_AW-1:0] addr;
        logic [INSTR_WIDTH-1:0]  wdata;
    } dmem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-requester round-robin pick. When both
//               requesters are active the one not granted last wins.
// Ports       : i_a_req, i_b_req  - requests
//               i_last_grant_b    - 1 when port B received the previous grant
//               o_valid           - at least one request present
//               o_grant_b         - 1 selects port B, 0 selects port A
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_last_grant_b,
    output logic o_valid,
    output logic o_grant_b
);

    always_comb begin
        o_valid = i_a_req | i_b_req;
        if (i_a_req && i_b_req) begin
            o_grant_b = ~i_last_grant_b;
        end else begin
            o_grant_b = i_b_req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the pipeline
//               memory stage (port A) and the debug/loader port (port B).
//               Each grant issues a one-cycle memory command, waits the
//               fixed read latency and returns a one-cycle ack with data.
// Ports       : clk, rst                   - clock, async active-high reset
//               {a,b}_req/_we/_addr/_wdata - requester command
//               {a,b}_ack/_rdata/_err      - requester response
//               stall_a                    - port A waiting for its ack
//               busy                       - sequencer not idle
//               mem_en/_we/_addr/_wdata    - memory command
//               mem_rdata                  - memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import riscv_params_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 65536,
    parameter int MEM_LATENCY = DMEM_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [ADDR_WIDTH-1:0]    a_addr,
    input  logic [DATA_WIDTH-1:0]    a_wdata,
    output logic                     a_ack,
    output logic [DATA_WIDTH-1:0]    a_rdata,
    output logic                     a_err,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [ADDR_WIDTH-1:0]    b_addr,
    input  logic [DATA_WIDTH-1:0]    b_wdata,
    output logic                     b_ack,
    output logic [DATA_WIDTH-1:0]    b_rdata,
    output logic                     b_err,
    output logic                     stall_a,
    output logic                     busy,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int c_MEM_AW = $clog2(DEPTH);

    dmem_arb_state_e        state_q, state_d;
    dmem_cmd_t              cmd_q, cmd_d;
    logic                   last_grant_b_q, last_grant_b_d;
    logic                   grant_b_q, grant_b_d;
    logic                   err_q, err_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0]  b_rdata_q, b_rdata_d;

    logic                   w_pick_valid;
    logic                   w_pick_b;
    logic                   w_sel_we;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;
    logic                   w_oor;

    rr_arb2 u_rr_arb2 (
        .i_a_req        (a_req),
        .i_b_req        (b_req),
        .i_last_grant_b (last_grant_b_q),
        .o_valid        (w_pick_valid),
        .o_grant_b      (w_pick_b)
    );

    assign w_sel_we    = w_pick_b ? b_we    : a_we;
    assign w_sel_addr  = w_pick_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_pick_b ? b_wdata : a_wdata;
    // Widen both sides so the range check is exact for any ADDR_WIDTH.
    assign w_oor       = 64'(w_sel_addr) >= 64'(DEPTH);

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        last_grant_b_d = last_grant_b_q;
        grant_b_d      = grant_b_q;
        err_d          = err_q;
        cnt_d          = cnt_q;
        a_rdata_d      = a_rdata_q;
        b_rdata_d      = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    last_grant_b_d = w_pick_b;
                    grant_b_d      = w_pick_b;
                    err_d          = w_oor;
                    if (w_oor) begin
                        // No memory command; the command registers keep the
                        // last issued command so mem_addr holds its value.
                        state_d = RESP;
                        if (w_pick_b) begin
                            b_rdata_d = '0;
                        end else begin
                            a_rdata_d = '0;
                        end
                    end else begin
                        state_d     = ACCESS;
                        cmd_d.we    = w_sel_we;
                        cmd_d.addr  = DMEM_WORD_AW'(w_sel_addr);
                        cmd_d.wdata = INSTR_WIDTH'(w_sel_wdata);
                    end
                end
            end
            ACCESS: begin
                cnt_d   = 4'(MEM_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!cmd_q.we) begin
                        if (grant_b_q) begin
                            b_rdata_d = mem_rdata;
                        end else begin
                            a_rdata_d = mem_rdata;
                        end
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cmd_q          <= '0;
            last_grant_b_q <= 1'b1;
            grant_b_q      <= 1'b0;
            err_q          <= 1'b0;
            cnt_q          <= 4'd0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            last_grant_b_q <= last_grant_b_d;
            grant_b_q      <= grant_b_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
        end
    end

    // Strobes decode straight from the state flop so an asynchronous reset
    // removes them within the same cycle.
    assign a_ack     = (state_q == RESP) && !grant_b_q;
    assign b_ack     = (state_q == RESP) &&  grant_b_q;
    assign a_err     = a_ack && err_q;
    assign b_err     = b_ack && err_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign stall_a   = a_req && !a_ack;
    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en && cmd_q.we;
    assign mem_addr  = c_MEM_AW'(cmd_q.addr);
    assign mem_wdata = mem_en ? DATA_WIDTH'(cmd_q.wdata) : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Bench for dmem_arbiter at memory latencies 1, 3 and 4. Each
//               instance has its own memory, requesters and a timing-level
//               reference model (grant time + fixed offsets per transaction).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DEPTH = 65536;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input int lat, input string tag,
                       input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL L%0d %s: got=%0h want=%0h", lat, tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom % 16)
            0:       return 32'd65536 + ($urandom % 8);
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd65535;
            default: return $urandom % 32;
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);

        logic        rst = 1'b1;
        logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
        logic [31:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0;
        logic        a_ack, b_ack, a_err, b_err, stall_a, busy, mem_en, mem_we;
        logic [31:0] a_rdata, b_rdata, mem_wdata;
        logic [31:0] mem_rdata = '0;
        logic [15:0] mem_addr;
        bit          en  = 1'b0;
        bit          fin = 1'b0;

        dmem_arbiter #(
            .DATA_WIDTH  (32),
            .ADDR_WIDTH  (32),
            .DEPTH       (DEPTH),
            .MEM_LATENCY (LAT)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .a_req     (a_req),
            .a_we      (a_we),
            .a_addr    (a_addr),
            .a_wdata   (a_wdata),
            .a_ack     (a_ack),
            .a_rdata   (a_rdata),
            .a_err     (a_err),
            .b_req     (b_req),
            .b_we      (b_we),
            .b_addr    (b_addr),
            .b_wdata   (b_wdata),
            .b_ack     (b_ack),
            .b_rdata   (b_rdata),
            .b_err     (b_err),
            .stall_a   (stall_a),
            .busy      (busy),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        // ---------------- memory environment ----------------
        bit [31:0] env_mem [DEPTH];
        int        rcnt  = 0;
        bit [15:0] raddr = '0;

        // Read data is valid only in cycle (mem_en cycle + LAT); junk otherwise.
        always @(posedge clk) begin
            int        nc;
            bit [15:0] ra;
            ra = raddr;
            if (mem_en && !mem_we) begin
                nc = LAT;
                ra = mem_addr;
            end else begin
                nc = (rcnt > 0) ? rcnt - 1 : 0;
            end
            if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
            rcnt  = nc;
            raddr = ra;
            mem_rdata <= (nc == 1) ? env_mem[ra] : $urandom;
        end

        // ---------------- reference model ----------------
        bit [31:0] ref_mem [DEPTH];
        int        cyc = 0, g = 0, ack_pe = 0, next_free = 0;
        bit        pend = 0, m_b = 0, m_err = 0, m_we = 0, last_b = 1;
        bit [31:0] m_addr = '0, m_wdata = '0;
        bit [31:0] exp_rd [2];
        bit [15:0] exp_maddr = '0;

        task automatic model_clear();
            pend      = 0;
            last_b    = 1;
            next_free = 0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            exp_maddr = '0;
        endtask

        always @(posedge rst) model_clear();

        always @(posedge clk) begin
            cyc++;
            if (rst) begin
                model_clear();
            end else begin
                if (pend && !m_err && cyc == g + 1 && m_we) ref_mem[m_addr[15:0]] = m_wdata;
                if (pend && !m_err && cyc == ack_pe && !m_we) exp_rd[m_b] = ref_mem[m_addr[15:0]];
                if (pend && cyc > ack_pe) pend = 0;
                if (!pend && cyc >= next_free && (a_req || b_req)) begin
                    m_b       = (a_req && b_req) ? !last_b : b_req;
                    last_b    = m_b;
                    m_we      = m_b ? b_we : a_we;
                    m_addr    = m_b ? b_addr : a_addr;
                    m_wdata   = m_b ? b_wdata : a_wdata;
                    m_err     = longint'(m_addr) >= DEPTH;
                    g         = cyc;
                    ack_pe    = cyc + (m_err ? 0 : 1 + LAT);
                    next_free = cyc + (m_err ? 2 : 3 + LAT);
                    pend      = 1;
                    if (m_err) exp_rd[m_b] = '0;
                    else       exp_maddr   = m_addr[15:0];
                end
            end
        end

        always @(negedge clk) begin
            bit ea, eb, ex;
            ea = pend && cyc == ack_pe && !m_b;
            eb = pend && cyc == ack_pe &&  m_b;
            ex = pend && !m_err && cyc == g;
            chk(LAT, "a_ack",     a_ack,     ea);
            chk(LAT, "b_ack",     b_ack,     eb);
            chk(LAT, "a_err",     a_err,     ea && m_err);
            chk(LAT, "b_err",     b_err,     eb && m_err);
            chk(LAT, "a_rdata",   a_rdata,   exp_rd[0]);
            chk(LAT, "b_rdata",   b_rdata,   exp_rd[1]);
            chk(LAT, "mem_en",    mem_en,    ex);
            chk(LAT, "mem_we",    mem_we,    ex && m_we);
            chk(LAT, "mem_wdata", mem_wdata, ex ? m_wdata : 32'd0);
            chk(LAT, "mem_addr",  mem_addr,  exp_maddr);
            chk(LAT, "busy",      busy,      pend && cyc >= g && cyc <= ack_pe);
            chk(LAT, "stall_a",   stall_a,   a_req && !ea);
        end

        // ---------------- requesters ----------------
        task automatic do_txn(input bit pb, input bit we, input logic [31:0] addr,
                              input logic [31:0] wd, input bit keep);
            int n;
            bit done;
            n    = 0;
            done = 0;
            @(negedge clk);
            #1;
            if (pb) begin
                b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
            end else begin
                a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
            end
            while (!done) begin
                @(negedge clk);
                if (rst) begin
                    done = 1;
                    keep = 0;
                end else if (pb ? b_ack : a_ack) begin
                    done = 1;
                end else if (++n > 64) begin
                    chk(LAT, "ack_timeout", pb ? b_ack : a_ack, 1);
                    done = 1;
                    keep = 0;
                end
            end
            #1;
            if (!keep) begin
                if (pb) b_req = 1'b0;
                else    a_req = 1'b0;
            end
        endtask

        initial begin
            forever begin
                @(negedge clk);
                if (en && !rst) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    if (en) do_txn(1'b0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'b0);
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                if (en && !rst) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    if (en) do_txn(1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'b0);
                end
            end
        end

        // ---------------- directed sequence, resets, random phase ----------------
        initial begin
            for (int k = 0; k < DEPTH; k++) begin
                env_mem[k] = (k * 32'h0100_0193) ^ 32'h5A5A_0000;
                ref_mem[k] = env_mem[k];
            end
            env_mem[5] = 32'h2A;
            ref_mem[5] = 32'h2A;
            repeat (3) @(negedge clk);
            rst = 1'b0;

            do_txn(1'b0, 1'b0, 32'd5, 32'd0, 1'b0);
            do_txn(1'b1, 1'b1, 32'd100, 32'hDEAD, 1'b0);
            do_txn(1'b1, 1'b0, 32'd100, 32'd0, 1'b0);
            fork
                begin
                    do_txn(1'b0, 1'b0, 32'd7, 32'd0, 1'b1);
                    do_txn(1'b0, 1'b1, 32'd8, 32'h1234, 1'b0);
                end
                begin
                    do_txn(1'b1, 1'b0, 32'd9, 32'd0, 1'b1);
                    do_txn(1'b1, 1'b1, 32'd10, 32'h5678, 1'b0);
                end
            join
            do_txn(1'b0, 1'b0, 32'd65536, 32'd0, 1'b0);
            do_txn(1'b1, 1'b0, 32'd65535, 32'd0, 1'b0);

            repeat (4) begin
                fork
                    do_txn(1'($urandom_range(0, 1)), 1'b0, $urandom % 32, 32'd0, 1'b0);
                    begin
                        int n;
                        n = 0;
                        while (!busy && n < 10) begin
                            @(negedge clk);
                            n++;
                        end
                        chk(LAT, "busy_before_rst", busy, 1);
                        repeat ($urandom_range(0, LAT + 1)) @(posedge clk);
                        #2 rst = 1'b1;
                        #1;
                        chk(LAT, "rst_busy",   busy,          0);
                        chk(LAT, "rst_mem_en", mem_en,        0);
                        chk(LAT, "rst_acks",   a_ack | b_ack, 0);
                        chk(LAT, "rst_errs",   a_err | b_err, 0);
                        chk(LAT, "rst_rdata",  a_rdata | b_rdata, 0);
                        chk(LAT, "rst_maddr",  mem_addr,      0);
                        @(negedge clk);
                        @(negedge clk);
                        rst = 1'b0;
                    end
                join
                fork
                    do_txn(1'b0, 1'b0, $urandom % 32, 32'd0, 1'b0);
                    do_txn(1'b1, 1'b0, $urandom % 32, 32'd0, 1'b0);
                join
                do_txn(1'b1, 1'b1, $urandom % 32, $urandom, 1'b0);
            end

            en = 1'b1;
            repeat (1500) @(negedge clk);
            en = 1'b0;
            repeat (100) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        chk(0, "finish_timeout", {g_inst[2].fin, g_inst[1].fin, g_inst[0].fin}, 3'b111);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-port data memory. It shares the memory between the pipeline memory-access stage (port A) and the debug/program-loader port (port B). Each requester uses a req/ack handshake. The block issues a one-cycle memory command, waits the fixed memory read latency, then returns an acknowledge with read data. It also produces the pipeline stall while port A is waiting.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width (equals INSTR_WIDTH)
- ADDR_WIDTH, 32, requester address width
- DEPTH, 65536, number of valid words (equals DATA_MEM_DEPTH)
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- a_req, b_req  in  1  request; held with its fields stable until the matching ack
- a_we, b_we  in  1  1 = store, 0 = load
- a_addr, b_addr  in  ADDR_WIDTH  word address
- a_wdata, b_wdata  in  DATA_WIDTH  store data
- a_ack, b_ack  out  1  one-cycle completion pulse
- a_rdata, b_rdata  out  DATA_WIDTH  load data; valid with ack, held until the next ack on that port
- a_err, b_err  out  1  valid with ack; 1 = address out of range
- stall_a  out  1  a_req & ~a_ack, combinational
- busy  out  1  state != IDLE
- mem_en, mem_we  out  1  memory command strobe and write enable
- mem_addr  out  $clog2(DEPTH)  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port not granted last (round-robin via `last_grant`).
  - The granted port's we/addr/wdata are registered into the command registers.
  - Address ≥ DEPTH: go to RESP with err set. No memory command is issued.
  - Otherwise: go to ACCESS. `last_grant` updates on every grant, including error grants.
- **ACCESS** (one cycle): mem_en=1; mem_we, mem_addr and mem_wdata come from the command registers. Next state is WAIT.
- **WAIT**
  - A counter loads MEM_LATENCY-1 on entry and decrements each cycle.
  - When the counter reaches 0, mem_rdata is captured into the granted port's rdata register (loads only) and the next state is RESP.
  - A store leaves rdata unchanged.
- **RESP** (one cycle): the granted port's ack=1. err=1 only for an out-of-range grant; in that case rdata is forced to 0. Requests are ignored in RESP. Next state is IDLE.
- Requester rule: drop req (or present a new transaction) on the edge where ack is seen. A req still high in IDLE is a new transaction.
- mem_en, mem_we and mem_wdata are 0 outside ACCESS. mem_addr holds its last value.

## Timing
- Requests are sampled at edge 0 in IDLE.
- In-range access:
  - mem_en is high in cycle 1.
  - WAIT spans cycles 2..1+MEM_LATENCY.
  - ack is high in cycle 2+MEM_LATENCY.
  - With MEM_LATENCY=1 this means ack in cycle 3 and 4 cycles per transaction including the return to IDLE.
  - Loads and stores have identical timing.
- Out-of-range access: ack and err are high in cycle 1; the transaction takes 2 cycles.
- Throughput is one transaction per 3+MEM_LATENCY cycles. Under both ports' constant requests, grants strictly alternate.
- Reset values: state=IDLE, last_grant=B (so port A wins the first tie), counter=0. All outputs are 0: all acks, errs and rdata, mem_en, mem_we, mem_addr, mem_wdata, busy.
- Reset mid-transaction: outputs clear asynchronously and immediately, and the transaction is abandoned with no ack. If reset occurs during ACCESS, mem_en drops within the same cycle. The requester must re-issue after reset.
- stall_a is combinational from a_req and is therefore high in the cycle a_req rises.

## Structure
- riscv_params_pkg gains:
  - `typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} dmem_arb_state_e;`
  - `typedef struct packed {we, addr, wdata} dmem_cmd_t;`
  - constant `DMEM_LATENCY`, used as the MEM_LATENCY default at top level.
- Sub-module rr_arb2: combinational two-request round-robin pick from (a_req, b_req, last_grant) that outputs a grant select. `last_grant` itself is registered in dmem_arbiter.

## Test plan
- Reset, then an a_req load of addr 5 with memory word 5 = 0x2A (MEM_LATENCY=1) -> mem_en in cycle 1 with mem_addr=5; a_ack, a_rdata=0x2A, a_err=0 in cycle 3; stall_a high in cycles 0..2.
- b_req store of 0xDEAD to addr 100, then b_req load of addr 100 -> one mem_en cycle with mem_we=1 and mem_wdata=0xDEAD; the load returns b_rdata=0xDEAD.
- a_req and b_req asserted together and held for 4 transactions -> grant order A, B, A, B; no ack overlap; busy low for exactly one cycle between transactions.
- a_req load with addr=65536 -> a_ack, a_err=1, a_rdata=0 in cycle 1; mem_en never asserted.
- Reset asserted mid-WAIT with MEM_LATENCY=3 -> all outputs 0 immediately, no ack; after release, a b_req is served first only if a_req is low.
- MEM_LATENCY=4 load -> ack in cycle 6; data captured from mem_rdata in cycle 5 only.
